mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Sequences each access as issue, fixed-latency wait, then response.
- Drives per-requester stall signals into the pipeline.
- Gives fixed priority to the memory stage, with an anti-starvation guarantee for fetch.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 2, cycles from memory sampling mem_en to mem_rdata valid; must be ≥1
- STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced; must be ≥1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_rdata  out  DATA_W  last fetch read data
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held until dm_ready
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  last data read result
- dm_ready  out  1  one-cycle completion pulse for data
- stall_if  out  1  fetch stall
- stall_mem  out  1  memory-stage stall
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, valid with mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after the mem_en cycle

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE; wait counter and starve counter clear.
  - All outputs go to 0, including if_rdata, dm_rdata, mem_addr, mem_wdata and mem_we.
  - Any outstanding memory response is discarded; no ready pulse is issued for it.
- States:
  - IDLE: arbitrate. If no request, stay in IDLE. Otherwise grant, latch the request, and go to ISSUE.
  - ISSUE: mem_en = 1 for exactly this cycle. Load wait counter with MEM_LATENCY. Go to WAIT.
  - WAIT: decrement the counter each cycle. In the final WAIT cycle (counter = 1), capture mem_rdata into the granted side's rdata register on a read. Then go to RESP.
  - RESP: granted side's ready = 1 for this cycle only. Go to IDLE.
- Latency:
  - A request first seen in IDLE at cycle 0 gives mem_en at cycle 1 and ready at cycle MEM_LATENCY+2.
  - Next arbitration is at cycle MEM_LATENCY+3.
- Grant latch (at the IDLE→ISSUE edge):
  - mem_addr, mem_we and mem_wdata are registered.
  - Fetch grant: mem_addr = if_addr, mem_we = 0, mem_wdata unchanged.
  - Data grant: mem_addr = dm_addr, mem_we = dm_we, mem_wdata = dm_wdata.
  - These values hold until the next grant.
- Arbitration:
  - Data wins by default.
  - Starve counter increments on each data grant made while if_req = 1, saturating at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT and if_req = 1, fetch wins.
  - Any fetch grant clears the counter.
- Writes: the ready pulse has the same timing as a read; dm_rdata is not updated.
- rdata registers: only the granted side's register updates on a read; otherwise both hold their value.
- Stall outputs (combinational):
  - stall_if = if_req & ~if_ready.
  - stall_mem = dm_req & ~dm_ready.
- Handshake:
  - Requests are sampled only in IDLE.
  - A requester holding req through its ready cycle is treated as a new request at the next IDLE; the requester updates its address on the ready edge.
- Request dropped mid-transaction (e.g. pipeline flush): the access still completes and ready still pulses. Nothing new issues unless req is high in IDLE.
- Addresses pass through unchecked (no alignment check).
- mem_en is never high in two consecutive cycles.

Test Plan:
1. Assert rst mid-run, asynchronously between edges → all outputs 0 immediately, before the next clock edge; stall_if and stall_mem follow the request inputs.
2. Fetch read, with MEM_LATENCY = 2:
   - Stimulus: if_req = 1, if_addr = 0x10 at cycle 0; mem_rdata = 0x00500293 at cycle 3.
   - Response: mem_en = 1, mem_addr = 0x10, mem_we = 0 at cycle 1; if_ready = 1 and if_rdata = 0x00500293 at cycle 4; stall_if = 1 for cycles 0–3.
3. Simultaneous requests:
   - Stimulus: if_req to 0x40 and a data write (dm_we = 1, dm_addr = 0x20, dm_wdata = 0xDEADBEEF) at cycle 0.
   - Response: data access first, with mem_we = 1 at cycle 1 and dm_ready at cycle 4; fetch mem_en at cycle 6 with mem_addr = 0x40; if_ready at cycle 9.
4. Starvation, with STARVE_LIMIT = 4: dm_req and if_req held high continuously → exactly 4 data grants, then 1 fetch grant, then data grants again.
5. Reset during WAIT → state returns to IDLE; no ready pulse occurs, even when mem_rdata arrives later. A new fetch after reset release completes with the normal 4-cycle latency.
6. if_req dropped during WAIT → if_ready still pulses at cycle 4; no further mem_en is issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// data memory stage. Each access runs IDLE -> ISSUE -> WAIT(xMEM_LATENCY) -> RESP.
// Data requests win by default; fetch is forced once STARVE_LIMIT consecutive
// data grants have been made while fetch was waiting.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WAIT_W   = $clog2(MEM_LATENCY + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LOAD  = WAIT_W'(MEM_LATENCY);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } stateT;

  stateT               state, stateNext;
  logic                grantData, grantDataNext;   // 1 = data side owns the access
  logic [WAIT_W-1:0]   waitCnt, waitCntNext;
  logic [STARVE_W-1:0] starveCnt, starveCntNext;

  logic              memEnNext, memWeNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [DATA_W-1:0] memWdataNext;
  logic              ifReadyNext, dmReadyNext;
  logic [DATA_W-1:0] ifRdataNext, dmRdataNext;
  logic              fetchWins;

  // Stalls track the live request so a flush drops them in the same cycle.
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;

  // Fetch only wins when data is idle or fetch has been starved long enough.
  assign fetchWins = if_req & (~dm_req | (starveCnt == STARVE_MAX));

  // Next-state, grant latch, wait counting and response capture.
  always_comb begin
    stateNext     = state;
    grantDataNext = grantData;
    waitCntNext   = waitCnt;
    starveCntNext = starveCnt;
    memEnNext     = 1'b0;
    memWeNext     = mem_we;
    memAddrNext   = mem_addr;
    memWdataNext  = mem_wdata;
    ifReadyNext   = 1'b0;
    dmReadyNext   = 1'b0;
    ifRdataNext   = if_rdata;
    dmRdataNext   = dm_rdata;

    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          stateNext = ISSUE;
          memEnNext = 1'b1;
          if (fetchWins) begin
            grantDataNext = 1'b0;
            memAddrNext   = if_addr;
            memWeNext     = 1'b0;
            starveCntNext = '0;
          end else begin
            grantDataNext = 1'b1;
            memAddrNext   = dm_addr;
            memWeNext     = dm_we;
            memWdataNext  = dm_wdata;
            if (if_req && (starveCnt != STARVE_MAX)) begin
              starveCntNext = starveCnt + STARVE_W'(1);
            end
          end
        end
      end
      ISSUE: begin
        waitCntNext = WAIT_LOAD;
        stateNext   = WAIT;
      end
      WAIT: begin
        if (waitCnt == WAIT_W'(1)) begin
          stateNext = RESP;
          if (grantData) begin
            dmReadyNext = 1'b1;
            if (!mem_we) begin
              dmRdataNext = mem_rdata;
            end
          end else begin
            ifReadyNext = 1'b1;
            ifRdataNext = mem_rdata;
          end
        end else begin
          waitCntNext = waitCnt - WAIT_W'(1);
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grantData <= 1'b0;
      waitCnt   <= '0;
      starveCnt <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state     <= stateNext;
      grantData <= grantDataNext;
      waitCnt   <= waitCntNext;
      starveCnt <= starveCntNext;
      mem_en    <= memEnNext;
      mem_we    <= memWeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      if_ready  <= ifReadyNext;
      dm_ready  <= dmReadyNext;
      if_rdata  <= ifRdataNext;
      dm_rdata  <= dmRdataNext;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random request traffic,
// checked every cycle against a transaction-level timing/arbitration model.
module tb_mem_port_arbiter;

  localparam int LAT   = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        ifReq, dmReq, dmWe;
  logic [31:0] ifAddr, dmAddr, dmWdata, memRdata;
  logic [31:0] ifRdata, dmRdata, memAddr, memWdata;
  logic        ifReady, dmReady, stallIf, stallMem, memEn, memWe;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ready(ifReady),
    .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
    .dm_rdata(dmRdata), .dm_ready(dmReady),
    .stall_if(stallIf), .stall_mem(stallMem),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  int cyc     = 0;

  // Reference model: one access at a time, timed from its grant cycle.
  int          grantCycle, freeCycle, starve;
  bit          gData, gWe;
  logic [31:0] gAddr, gWdata, gRd;
  logic [31:0] expMemAddr, expMemWdata, expIfRdata, expDmRdata;
  bit          expMemWe, curIfReady, curDmReady;
  logic [31:0] memImage[logic [31:0]];
  logic [31:0] rdataAt[int];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nErrors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, want);
    end
  endtask

  function automatic logic [31:0] readMem(input logic [31:0] a);
    if (memImage.exists(a)) return memImage[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] randAddr();
    return 32'($urandom_range(0, 63));
  endfunction

  task automatic resetModel();
    grantCycle  = -100;
    freeCycle   = 0;
    starve      = 0;
    gData       = 1'b0;
    gWe         = 1'b0;
    gAddr       = '0;
    gWdata      = '0;
    gRd         = '0;
    expMemAddr  = '0;
    expMemWdata = '0;
    expIfRdata  = '0;
    expDmRdata  = '0;
    expMemWe    = 1'b0;
    curIfReady  = 1'b0;
    curDmReady  = 1'b0;
  endtask

  // Predict and compare the registered outputs for the current cycle.
  task automatic checkOutputs();
    bit expMemEn;
    if (cyc == grantCycle + 1) begin
      expMemAddr = gAddr;
      expMemWe   = gWe;
      if (gData) expMemWdata = gWdata;
    end
    curIfReady = (cyc == grantCycle + LAT + 2) && !gData;
    curDmReady = (cyc == grantCycle + LAT + 2) && gData;
    if (curIfReady) expIfRdata = gRd;
    if (curDmReady && !gWe) expDmRdata = gRd;
    expMemEn = (cyc == grantCycle + 1);
    checkVal("memEn",    32'(memEn),    32'(expMemEn));
    checkVal("memAddr",  memAddr,       expMemAddr);
    checkVal("memWe",    32'(memWe),    32'(expMemWe));
    checkVal("memWdata", memWdata,      expMemWdata);
    checkVal("ifReady",  32'(ifReady),  32'(curIfReady));
    checkVal("dmReady",  32'(dmReady),  32'(curDmReady));
    checkVal("ifRdata",  ifRdata,       expIfRdata);
    checkVal("dmRdata",  dmRdata,       expDmRdata);
  endtask

  // Arbitration decision for the inputs the DUT samples at the end of this cycle.
  task automatic modelArb();
    bit fetchWins;
    if (rst) return;
    if (cyc < freeCycle || !(ifReq || dmReq)) return;
    fetchWins  = ifReq && (!dmReq || starve == LIMIT);
    grantCycle = cyc;
    freeCycle  = cyc + LAT + 3;
    if (fetchWins) begin
      gData  = 1'b0;
      gAddr  = ifAddr;
      gWe    = 1'b0;
      gRd    = readMem(ifAddr);
      starve = 0;
    end else begin
      gData  = 1'b1;
      gAddr  = dmAddr;
      gWe    = dmWe;
      gWdata = dmWdata;
      if (dmWe) memImage[dmAddr] = dmWdata;
      else      gRd = readMem(dmAddr);
      if (ifReq && starve < LIMIT) starve++;
    end
  endtask

  // Advance to the next cycle, check outputs, act as the memory.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    checkOutputs();
    if (memEn === 1'b1 && memWe === 1'b0) rdataAt[cyc + LAT] = readMem(memAddr);
  endtask

  // Inputs for this cycle are final: drive memory data, check stalls, arbitrate.
  task automatic settle();
    memRdata = rdataAt.exists(cyc) ? rdataAt[cyc] : $urandom();
    #1;
    checkVal("stallIf",  32'(stallIf),  32'(ifReq & ~curIfReady));
    checkVal("stallMem", 32'(stallMem), 32'(dmReq & ~curDmReady));
    modelArb();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      settle();
    end
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic doReset(input int hold);
    #1;
    rst = 1'b1;
    #1;
    checkVal("rstMemEn",    32'(memEn),    32'd0);
    checkVal("rstMemWe",    32'(memWe),    32'd0);
    checkVal("rstMemAddr",  memAddr,       32'd0);
    checkVal("rstMemWdata", memWdata,      32'd0);
    checkVal("rstIfReady",  32'(ifReady),  32'd0);
    checkVal("rstDmReady",  32'(dmReady),  32'd0);
    checkVal("rstIfRdata",  ifRdata,       32'd0);
    checkVal("rstDmRdata",  dmRdata,       32'd0);
    checkVal("rstStallIf",  32'(stallIf),  32'(ifReq));
    checkVal("rstStallMem", 32'(stallMem), 32'(dmReq));
    resetModel();
    idle(hold);
    tick();
    rst = 1'b0;
    settle();
  endtask

  // Random requesters: hold while waiting, occasionally flush.
  task automatic agents();
    if (ifReq) begin
      if (curIfReady) begin
        if ($urandom_range(0, 1) == 0) ifAddr = randAddr();
        else ifReq = 1'b0;
      end else if ($urandom_range(0, 39) == 0) ifReq = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      ifReq  = 1'b1;
      ifAddr = randAddr();
    end
    if (dmReq) begin
      if (curDmReady) begin
        if ($urandom_range(0, 1) == 0) begin
          dmAddr  = randAddr();
          dmWe    = 1'($urandom_range(0, 1));
          dmWdata = $urandom();
        end else dmReq = 1'b0;
      end else if ($urandom_range(0, 39) == 0) dmReq = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      dmReq   = 1'b1;
      dmAddr  = randAddr();
      dmWe    = 1'($urandom_range(0, 1));
      dmWdata = $urandom();
    end
  endtask

  initial begin
    int seq[$];
    int wantSeq[6];
    int bound;
    int nextReset;

    rst = 1'b1;
    ifReq = 1'b0; ifAddr = '0;
    dmReq = 1'b0; dmWe = 1'b0; dmAddr = '0; dmWdata = '0;
    memRdata = '0;
    resetModel();
    idle(2);
    tick();
    rst = 1'b0;
    settle();
    idle(2);

    // Single fetch read with the documented latency and data.
    memImage[32'h10] = 32'h0050_0293;
    tick();
    ifReq = 1'b1; ifAddr = 32'h10;
    settle();
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin
        checkVal("aMemEn",   32'(memEn), 32'd1);
        checkVal("aMemAddr", memAddr,    32'h10);
        checkVal("aMemWe",   32'(memWe), 32'd0);
      end
      if (k == 4) begin
        checkVal("aIfReady", 32'(ifReady), 32'd1);
        checkVal("aIfRdata", ifRdata,      32'h0050_0293);
        ifReq = 1'b0;
      end
      settle();
    end
    idle(2);

    // Simultaneous fetch and data write: data first, fetch after.
    tick();
    ifReq = 1'b1; ifAddr = 32'h40;
    dmReq = 1'b1; dmWe = 1'b1; dmAddr = 32'h20; dmWdata = 32'hDEAD_BEEF;
    settle();
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) begin
        checkVal("bMemWe",    32'(memWe), 32'd1);
        checkVal("bMemAddr",  memAddr,    32'h20);
        checkVal("bMemWdata", memWdata,   32'hDEAD_BEEF);
      end
      if (k == 4) begin
        checkVal("bDmReady", 32'(dmReady), 32'd1);
        dmReq = 1'b0;
      end
      if (k == 6) begin
        checkVal("bFetchEn",   32'(memEn), 32'd1);
        checkVal("bFetchAddr", memAddr,    32'h40);
      end
      if (k == 9) begin
        checkVal("bIfReady", 32'(ifReady), 32'd1);
        ifReq = 1'b0;
      end
      settle();
    end
    idle(2);

    // Fetch dropped during the wait still completes, nothing reissues.
    tick();
    ifReq = 1'b1; ifAddr = 32'h8;
    settle();
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 2) ifReq = 1'b0;
      if (k == 4) checkVal("cIfReady", 32'(ifReady), 32'd1);
      if (k >= 5) checkVal("cNoReissue", 32'(memEn), 32'd0);
      settle();
    end

    // Both sides held: four data grants, one fetch, then data again.
    wantSeq = '{1, 1, 1, 1, 0, 1};
    tick();
    ifReq = 1'b1; ifAddr = randAddr();
    dmReq = 1'b1; dmWe = 1'b0; dmAddr = randAddr();
    settle();
    bound = 0;
    while (seq.size() < 6 && bound < 60) begin
      tick();
      if (ifReady) begin seq.push_back(0); ifAddr = randAddr(); end
      if (dmReady) begin seq.push_back(1); dmAddr = randAddr(); end
      settle();
      bound++;
    end
    checkVal("starveCount", 32'(seq.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < seq.size()) checkVal("starveSeq", 32'(seq[i]), 32'(wantSeq[i]));
    end
    tick();
    ifReq = 1'b0; dmReq = 1'b0;
    settle();
    idle(6);

    // Random traffic with occasional resets landing in the wait phase.
    nextReset = cyc + 150;
    for (int i = 0; i < 3000; i++) begin
      tick();
      agents();
      settle();
      if (cyc >= nextReset && (cyc == grantCycle + 2 || cyc == grantCycle + 3)) begin
        doReset(2);
        nextReset = cyc + 250;
      end
    end

    tick();
    ifReq = 1'b0; dmReq = 1'b0;
    settle();
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
